// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's instruction-memory, decode and resolve signals.
// The master modport is the fetch unit itself; slave is its environment.
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [23:0]     imem_data;
  logic            instr_valid;
  logic [23:0]     instr_out;
  logic [PC_W-1:0] instr_pc;
  logic            dec_ready;
  logic            resolve_valid;
  logic [1:0]      pc_cnt;
  logic            branch_taken;
  logic [PC_W-1:0] target;
  logic            halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, halted,
    input  imem_ack, imem_data, dec_ready, resolve_valid, pc_cnt,
           branch_taken, target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, halted,
    output imem_ack, imem_data, dec_ready, resolve_valid, pc_cnt,
           branch_taken, target
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch unit: one instruction in flight, from the
// memory request until control resolves the next PC (seq/branch/jump/halt).
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    WAIT_RES = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [23:0]     instr_q, instr_d;
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic            transfer;
  logic            resolveEn;
  logic [PC_W-1:0] nextPc;

  assign transfer  = (state_q == HOLD) && bus.dec_ready;
  // A resolve pulse counts in WAIT_RES, or together with the transfer itself.
  assign resolveEn = bus.resolve_valid && ((state_q == WAIT_RES) || transfer);

  always_comb begin
    nextPc = pc_q + 1'b1;
    unique case (bus.pc_cnt)
      PC_BRANCH: if (bus.branch_taken) nextPc = bus.target;
      PC_JUMP:   nextPc = bus.target;
      default:   nextPc = pc_q + 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          ipc_d   = pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.dec_ready) state_d = WAIT_RES;
      end
      WAIT_RES: state_d = WAIT_RES;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
    if (resolveEn) begin
      if (bus.pc_cnt == 2'b11) begin
        state_d = HALT;
      end else begin
        state_d = FETCH;
        pc_d    = nextPc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.halted      = (state_q == HALT);

  // PC_SEQ names the default arm of the next-PC select above.
  logic unusedSeq;
  assign unusedSeq = ^PC_SEQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand-written reset/halt
// sequences; all expectations are hand-computed constants.
module tb_fetch_unit;

  localparam int PC_W = 8;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [23:0] data;
    logic        ready;
    logic        res;
    logic [1:0]  pcCnt;
    logic        taken;
    logic [7:0]  tgt;
    logic        expReq;
    logic [7:0]  expAddr;
    logic        expValid;
    logic [23:0] expInstr;
    logic [7:0]  expPc;
    logic        expHalted;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic ack, input logic [23:0] data, input logic ready,
                        input logic res, input logic [1:0] pcCnt, input logic taken,
                        input logic [7:0] tgt, input logic expReq, input logic [7:0] expAddr,
                        input logic expValid, input logic [23:0] expInstr,
                        input logic [7:0] expPc, input logic expHalted);
    vec_t v;
    v = '{ack, data, ready, res, pcCnt, taken, tgt,
          expReq, expAddr, expValid, expInstr, expPc, expHalted};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus.imem_ack      = 1'b0;
    bus.imem_data     = 24'h0;
    bus.dec_ready     = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.pc_cnt        = 2'b00;
    bus.branch_taken  = 1'b0;
    bus.target        = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.imem_ack      = v.ack;
    bus.imem_data     = v.data;
    bus.dec_ready     = v.ready;
    bus.resolve_valid = v.res;
    bus.pc_cnt        = v.pcCnt;
    bus.branch_taken  = v.taken;
    bus.target        = v.tgt;
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    string s;
    s = $sformatf("v%0d", idx);
    checkOutput({s, ".req"},    32'(bus.imem_req),    32'(v.expReq));
    checkOutput({s, ".addr"},   32'(bus.imem_addr),   32'(v.expAddr));
    checkOutput({s, ".valid"},  32'(bus.instr_valid), 32'(v.expValid));
    checkOutput({s, ".instr"},  32'(bus.instr_out),   32'(v.expInstr));
    checkOutput({s, ".pc"},     32'(bus.instr_pc),    32'(v.expPc));
    checkOutput({s, ".halted"}, 32'(bus.halted),      32'(v.expHalted));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idleInputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Each row: inputs held this cycle, outputs expected this cycle (registered state).
    //     ack data      rdy res cnt tk tgt    req addr  vld instr     pc    hlt
    addVec(0, 24'h0,      0, 0, 2'b00, 0, 8'h00, 1, 8'h00, 0, 24'h000000, 8'h00, 0);
    addVec(0, 24'h0,      0, 0, 2'b00, 0, 8'h00, 1, 8'h00, 0, 24'h000000, 8'h00, 0);
    addVec(1, 24'h0C1234, 0, 0, 2'b00, 0, 8'h00, 1, 8'h00, 0, 24'h000000, 8'h00, 0);
    addVec(0, 24'h0,      0, 1, 2'b10, 0, 8'h99, 0, 8'h00, 1, 24'h0C1234, 8'h00, 0);
    addVec(0, 24'h0,      0, 0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 24'h0C1234, 8'h00, 0);
    addVec(0, 24'h0,      0, 0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 24'h0C1234, 8'h00, 0);
    addVec(0, 24'h0,      1, 0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 24'h0C1234, 8'h00, 0);
    addVec(0, 24'h0,      0, 0, 2'b00, 0, 8'h00, 0, 8'h00, 0, 24'h0C1234, 8'h00, 0);
    addVec(0, 24'h0,      0, 1, 2'b01, 1, 8'h40, 0, 8'h00, 0, 24'h0C1234, 8'h00, 0);
    addVec(1, 24'h111111, 0, 0, 2'b00, 0, 8'h00, 1, 8'h40, 0, 24'h0C1234, 8'h00, 0);
    addVec(0, 24'h0,      1, 1, 2'b10, 0, 8'h05, 0, 8'h40, 1, 24'h111111, 8'h40, 0);
    addVec(1, 24'h222222, 0, 0, 2'b00, 0, 8'h00, 1, 8'h05, 0, 24'h111111, 8'h40, 0);
    addVec(0, 24'h0,      1, 1, 2'b01, 0, 8'h77, 0, 8'h05, 1, 24'h222222, 8'h05, 0);
    addVec(0, 24'h0,      0, 1, 2'b11, 0, 8'h00, 1, 8'h06, 0, 24'h222222, 8'h05, 0);
    addVec(1, 24'h333333, 0, 0, 2'b00, 0, 8'h00, 1, 8'h06, 0, 24'h222222, 8'h05, 0);
    addVec(0, 24'h0,      1, 1, 2'b10, 0, 8'hFF, 0, 8'h06, 1, 24'h333333, 8'h06, 0);
    addVec(1, 24'h444444, 0, 0, 2'b00, 0, 8'h00, 1, 8'hFF, 0, 24'h333333, 8'h06, 0);
    addVec(1, 24'h999999, 1, 1, 2'b00, 0, 8'h00, 0, 8'hFF, 1, 24'h444444, 8'hFF, 0);
    addVec(1, 24'h555555, 0, 0, 2'b00, 0, 8'h00, 1, 8'h00, 0, 24'h444444, 8'hFF, 0);
    addVec(0, 24'h0,      1, 0, 2'b00, 0, 8'h00, 0, 8'h00, 1, 24'h555555, 8'h00, 0);
    addVec(1, 24'hAAAAAA, 0, 1, 2'b11, 0, 8'h00, 0, 8'h00, 0, 24'h555555, 8'h00, 0);
    addVec(1, 24'hBBBBBB, 0, 1, 2'b10, 0, 8'h33, 0, 8'h00, 0, 24'h555555, 8'h00, 1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
      step();
    end

    // Halted: requests must stay off whatever the environment does.
    for (int c = 0; c < 20; c++) begin
      bus.imem_ack      = 1'b1;
      bus.resolve_valid = 1'b1;
      bus.pc_cnt        = 2'b00;
      bus.dec_ready     = 1'b1;
      checkOutput($sformatf("halt%0d.req", c), 32'(bus.imem_req), 32'd0);
      checkOutput($sformatf("halt%0d.halted", c), 32'(bus.halted), 32'd1);
      step();
    end

    idleInputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstHalt.req",    32'(bus.imem_req),    32'd1);
    checkOutput("rstHalt.addr",   32'(bus.imem_addr),   32'(RESET_PC));
    checkOutput("rstHalt.halted", 32'(bus.halted),      32'd0);
    checkOutput("rstHalt.instr",  32'(bus.instr_out),   32'd0);

    // Move away from RESET_PC, then reset with an ack landing in the reset cycle.
    bus.imem_ack  = 1'b1;
    bus.imem_data = 24'h123456;
    step();
    bus.imem_ack      = 1'b0;
    bus.dec_ready     = 1'b1;
    bus.resolve_valid = 1'b1;
    bus.pc_cnt        = 2'b10;
    bus.target        = 8'h80;
    step();
    idleInputs();
    checkOutput("preRst.addr", 32'(bus.imem_addr), 32'h80);
    checkOutput("preRst.req",  32'(bus.imem_req),  32'd1);
    rst           = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 24'hBBBBBB;
    step();
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    checkOutput("ackRst.valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("ackRst.req",   32'(bus.imem_req),    32'd1);
    checkOutput("ackRst.addr",  32'(bus.imem_addr),   32'(RESET_PC));
    checkOutput("ackRst.instr", 32'(bus.instr_out),   32'd0);
    step();
    checkOutput("ackRst2.valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("ackRst2.req",   32'(bus.imem_req),    32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, the program-counter and instruction-address width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, the first fetch address after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have rst  in  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have imem_req  out  1  instruction-memory read request, held until acknowledged.
REQ-006 SHALL have imem_addr  out  PC_W  read address, stable while imem_req=1.
REQ-007 SHALL have imem_ack  in  1  one-cycle pulse: imem_data is valid this cycle.
REQ-008 SHALL have imem_data  in  24  instruction word; opcode is bits [23:18].
REQ-009 SHALL have instr_valid  out  1  instr_out/instr_pc hold a valid instruction for decode.
REQ-010 SHALL have instr_out  out  24  instruction presented to decode; its [23:18] drives the control unit opcode.
REQ-011 SHALL have instr_pc  out  PC_W  address of instr_out.
REQ-012 SHALL have dec_ready  in  1  decode accepts instr_out this cycle when instr_valid=1.
REQ-013 SHALL have resolve_valid  in  1  one-cycle pulse: pc_cnt/branch_taken/target resolve the last accepted instruction.
REQ-014 SHALL have pc_cnt  in  2  next-PC select from control: 00 seq, 01 branch, 10 jump, 11 halt.
REQ-015 SHALL have branch_taken  in  1  branch condition result (beq/bne), used only when pc_cnt=01.
REQ-016 SHALL have target  in  PC_W  absolute redirect address for a taken branch or jump.
REQ-017 SHALL have halted  out  1  fetch stopped by a halt until reset.

Function
REQ-018 SHALL implement FSM states FETCH (request outstanding), HOLD (instruction presented, waiting dec_ready), WAIT_RES (accepted, waiting resolve_valid), HALT.
REQ-019 SHALL in FETCH drive imem_req=1, imem_addr=pc; on imem_ack latch instr_out=imem_data, instr_pc=pc, set instr_valid=1 next cycle, go to HOLD.
REQ-020 SHALL in HOLD keep instr_out/instr_pc stable and instr_valid=1 while dec_ready=0; transfer occurs only when instr_valid=1 and dec_ready=1.
REQ-021 SHALL on transfer clear instr_valid the following cycle and go to WAIT_RES; no new fetch issues before resolution (one instruction in flight).
REQ-022 SHALL on resolve_valid in WAIT_RES: pc_cnt=00 or (01 with branch_taken=0) -> pc=pc+1; pc_cnt=01 with branch_taken=1 or pc_cnt=10 -> pc=target; then go to FETCH the next cycle.
REQ-023 SHALL on resolve_valid with pc_cnt=11 go to HALT, set halted=1, and never assert imem_req again until reset.
REQ-024 SHALL permit resolve_valid in the same cycle as the transfer; the resolution then applies immediately and WAIT_RES lasts zero cycles.
REQ-025 SHALL wrap pc modulo 2^PC_W: pc=2^PC_W-1 sequential -> 0.
REQ-026 SHALL ignore resolve_valid outside WAIT_RES or the transfer cycle, and ignore imem_ack outside FETCH.
REQ-027 SHALL present imem_ack arriving in the first cycle of FETCH as a valid response (zero-wait memory allowed, minimum 2 cycles per fetch).

Reset
REQ-028 SHALL on rst=1 set pc=RESET_PC, state=FETCH, instr_valid=0, instr_out=0, instr_pc=0, halted=0; imem_req=1 from the first cycle after rst deasserts.
REQ-029 SHALL on rst asserted mid-operation (any state, including outstanding request or HALT) abandon all state; an imem_ack in the rst cycle is dropped.

Verification
REQ-030 SHALL cover reset then ack after 2 wait cycles with imem_data=24'h0C1234 -> imem_addr=0, instr_valid=1, instr_out=24'h0C1234, instr_pc=0.
REQ-031 SHALL cover dec_ready low 3 cycles -> instr_out unchanged, instr_valid=1 throughout, a single transfer on the cycle dec_ready=1.
REQ-032 SHALL cover resolve pc_cnt=01 with branch_taken=1, target=8'h40 -> next imem_addr=8'h40; with branch_taken=0 at pc=5 -> imem_addr=6.
REQ-033 SHALL cover pc=8'hFF, pc_cnt=00 -> next imem_addr=8'h00.
REQ-034 SHALL cover pc_cnt=11 -> halted=1, imem_req stays 0 for 20 cycles; rst -> imem_addr=RESET_PC, halted=0.
REQ-035 SHALL cover rst pulsed while imem_req=1 with imem_ack in the same cycle -> instr_valid stays 0, fetch restarts at RESET_PC.
